// File: rtl/lcd_writer_if.sv
// Stream interface carrying 9-bit LCD words {RS, DB[7:0]} into lcd_writer.
//
// Handshake: a word moves on a rising clock edge where valid_i and ready_o
// are both 1. The source may raise valid_i at any time and may drop it or
// change data_i freely while ready_o is 0; the sink ignores both until it
// raises ready_o. ready_o never depends combinationally on valid_i.
interface lcd_writer_if;
    logic [8:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/lcd_writer.sv
// HD44780-style 8-bit parallel write engine. Takes one {RS, DB} word per
// handshake and plays it onto the LCD pins with setup / enable / hold timing,
// followed by a settle gap that is longer for clear/home commands.
module lcd_writer #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2000,
    parameter int T_LONG  = 82000,
    parameter int CNT_W   = 17
) (
    input  logic         clock_i,
    input  logic         rstn_i,
    lcd_writer_if.slave  stream,
    output logic         lcd_rs_o,
    output logic         lcd_rw_o,
    output logic         lcd_e_o,
    output logic [7:0]   lcd_db_o,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_LONG - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_d;
    logic [7:0]       db_d;
    logic             ready_d;
    logic             e_d;
    logic             long_cmd;
    logic [CNT_W-1:0] gap_last;

    // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
    assign long_cmd = !lcd_rs_o && (lcd_db_o[7:2] == 6'd0) && (lcd_db_o[1:0] != 2'd0);
    assign gap_last = long_cmd ? LONG_LAST : GAP_LAST;

    // Write-only interface: R/W is never driven high.
    assign lcd_rw_o  = 1'b0;
    assign dbg_state = state_q;

    // Next-state, counter and next-output decode; outputs are registered from
    // the next state so E and ready line up exactly with state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        rs_d    = lcd_rs_o;
        db_d    = lcd_db_o;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (stream.valid_i && stream.ready_o) begin
                    rs_d    = stream.data_i[8];
                    db_d    = stream.data_i[7:0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == EN_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == gap_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == IDLE);
        e_d     = (state_d == PULSE);
    end

    // State, counter and all pin/handshake outputs; reset clears everything
    // at once, including dropping E mid-pulse.
    always_ff @(posedge clock_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            lcd_rs_o       <= 1'b0;
            lcd_db_o       <= 8'd0;
            lcd_e_o        <= 1'b0;
            stream.ready_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lcd_rs_o       <= rs_d;
            lcd_db_o       <= db_d;
            lcd_e_o        <= e_d;
            stream.ready_o <= ready_d;
        end
    end

endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer with short timing parameters
// (setup 1, enable 3, hold 1, gap 4, long gap 10).
module tb_lcd_writer;

    localparam int TS = 1;
    localparam int TE = 3;
    localparam int TH = 1;
    localparam int TG = 4;
    localparam int TL = 10;

    logic       clk;
    logic       rstn;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;
    logic [2:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    lcd_writer_if s_if ();

    lcd_writer #(
        .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_GAP(TG), .T_LONG(TL), .CNT_W(17)
    ) dut (
        .clock_i  (clk),
        .rstn_i   (rstn),
        .stream   (s_if.slave),
        .lcd_rs_o (lcd_rs),
        .lcd_rw_o (lcd_rw),
        .lcd_e_o  (lcd_e),
        .lcd_db_o (lcd_db),
        .dbg_state(dbg_state)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges the run
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gap_of(input logic [8:0] w);
        return (w[8] == 1'b0 && w[7:2] == 6'd0 && w[1:0] != 2'd0) ? TL : TG;
    endfunction

    // Wait (at negedges) until ready_o is high, bounded by max_cyc cycles
    task automatic wait_ready(output bit ok, input int max_cyc);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (s_if.ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Send one word and check every cycle until ready returns; optionally
    // scramble valid/data while the writer is busy.
    task automatic send_word(input logic [8:0] w, input bit toggle);
        bit ok;
        int last;
        wait_ready(ok, 40);
        if (!ok) return;
        s_if.data_i  = w;
        s_if.valid_i = 1'b1;
        @(negedge clk);
        s_if.valid_i = 1'b0;
        check("acc_rs", 32'(lcd_rs), 32'(w[8]));
        check("acc_db", 32'(lcd_db), 32'(w[7:0]));
        check("acc_e", 32'(lcd_e), 32'd0);
        check("acc_ready", 32'(s_if.ready_o), 32'd0);
        last = TS + TE + TH + gap_of(w);
        for (int j = 1; j <= last; j++) begin
            if (toggle) begin
                s_if.valid_i = 1'($urandom_range(0, 1));
                s_if.data_i  = 9'($urandom_range(0, 511));
            end
            @(negedge clk);
            check("busy_e", 32'(lcd_e), 32'((j >= TS && j < TS + TE) ? 1 : 0));
            check("busy_ready", 32'(s_if.ready_o), 32'((j == last) ? 1 : 0));
            check("busy_rs", 32'(lcd_rs), 32'(w[8]));
            check("busy_db", 32'(lcd_db), 32'(w[7:0]));
            check("busy_rw", 32'(lcd_rw), 32'd0);
        end
        s_if.valid_i = 1'b0;
    endtask

    initial begin
        bit ok;
        int acc;
        int prev_acc;
        logic [8:0] w;

        // Reset behaviour
        rstn         = 1'b0;
        s_if.valid_i = 1'b0;
        s_if.data_i  = 9'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(s_if.ready_o), 32'd0);
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_db", 32'(lcd_db), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rstn = 1'b1;
        #1;
        check("rel_ready_before_edge", 32'(s_if.ready_o), 32'd0);
        @(negedge clk);
        check("rel_ready_after_edge", 32'(s_if.ready_o), 32'd1);
        check("rel_e", 32'(lcd_e), 32'd0);
        check("rel_db", 32'(lcd_db), 32'd0);

        // Single data, long command, normal command
        send_word(9'h141, 1'b0);
        send_word(9'h001, 1'b0);
        send_word(9'h038, 1'b0);
        // Busy-time scrambling of valid/data, data and home command
        send_word(9'h1A5, 1'b1);
        send_word(9'h002, 1'b1);
        send_word(9'h003, 1'b0);
        send_word(9'h004, 1'b0);

        // Streaming with valid held high
        check("idle_db_holds", 32'(lcd_db), 32'h04);
        prev_acc     = 0;
        s_if.valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_if.data_i = 9'(i);
            wait_ready(ok, 40);
            if (!ok) break;
            acc = cyc + 1;
            @(negedge clk);
            check("stream_db", 32'(lcd_db), 32'(i));
            check("stream_rs", 32'(lcd_rs), 32'd0);
            check("stream_ready", 32'(s_if.ready_o), 32'd0);
            if (i > 0) begin
                w = 9'(i - 1);
                check("stream_spacing", 32'(acc - prev_acc), 32'(TS + TE + TH + gap_of(w) + 1));
            end
            prev_acc = acc;
        end
        s_if.valid_i = 1'b0;
        wait_ready(ok, 40);
        check("stream_end_db", 32'(lcd_db), 32'h0F);

        // Reset while E is high
        s_if.data_i  = 9'h155;
        s_if.valid_i = 1'b1;
        @(negedge clk);
        s_if.valid_i = 1'b0;
        @(negedge clk);
        check("mid_e_high", 32'(lcd_e), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_e", 32'(lcd_e), 32'd0);
        check("mid_rst_rs", 32'(lcd_rs), 32'd0);
        check("mid_rst_db", 32'(lcd_db), 32'd0);
        check("mid_rst_ready", 32'(s_if.ready_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("mid_rel_ready0", 32'(s_if.ready_o), 32'd0);
        @(negedge clk);
        check("mid_rel_ready1", 32'(s_if.ready_o), 32'd1);
        check("mid_rel_db", 32'(lcd_db), 32'd0);
        send_word(9'h038, 1'b0);
        send_word(9'h101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
